// File: rtl/util_debounce_repeat.sv
`default_nettype none
// ============================================================================
//  Module   : util_debounce_repeat
//  Purpose  : Button conditioner for the OSD/keypad input path. Synchronizes
//             a raw asynchronous button line, rejects contact bounce, and
//             produces a clean level, one-cycle press/release strobes, and an
//             auto-repeat strobe (on press, after REPEAT_DELAY, then every
//             REPEAT_RATE cycles while held).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEBOUNCE     : consecutive differing samples needed to change level
//    REPEAT_DELAY : cycles from press strobe to first auto-repeat
//    REPEAT_RATE  : cycles between subsequent auto-repeats
//  Ports
//    clk          in  : clock, rising edge
//    res_n        in  : asynchronous active-low reset
//    d            in  : raw button line, active-high, asynchronous
//    level        out : debounced button state
//    press        out : one-cycle strobe on level 0->1
//    release_stb  out : one-cycle strobe on level 1->0
//                       ("release" is a reserved word in SystemVerilog)
//    rep          out : one-cycle strobe on press and on every auto-repeat
// ============================================================================
module util_debounce_repeat #(
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 10,
    parameter int REPEAT_RATE  = 3
) (
    input  logic clk,
    input  logic res_n,
    input  logic d,
    output logic level,
    output logic press,
    output logic release_stb,
    output logic rep
);

    // ------------------------------------------------------------------
    // Counter widths and terminal counts
    // ------------------------------------------------------------------
    localparam int DCNT_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int RCNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCNT_W   = (RCNT_MAX > 1) ? $clog2(RCNT_MAX) : 1;

    localparam logic [DCNT_W-1:0] DCNT_TC  = DCNT_W'(DEBOUNCE - 1);
    localparam logic [RCNT_W-1:0] DELAY_TC = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RATE_TC  = RCNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic              s1;
    logic              q;
    logic [DCNT_W-1:0] dcnt;

    logic              upd;     // level changes on this edge
    logic              rise;
    logic              fall;

    state_t            state;
    state_t            state_nxt;
    logic [RCNT_W-1:0] rcnt;
    logic [RCNT_W-1:0] rcnt_nxt;
    logic              rep_nxt;

    // ------------------------------------------------------------------
    // Two-flop synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: level flips only after DEBOUNCE consecutive samples of q
    // that differ from it; any agreeing sample restarts the count.
    // ------------------------------------------------------------------
    assign upd  = (q != level) && (dcnt == DCNT_TC);
    assign rise = upd & q;
    assign fall = upd & ~q;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            dcnt        <= '0;
            level       <= 1'b0;
            press       <= 1'b0;
            release_stb <= 1'b0;
        end else begin
            press       <= rise;
            release_stb <= fall;
            if (q == level) begin
                dcnt <= '0;
            end else if (upd) begin
                level <= q;
                dcnt  <= '0;
            end else begin
                dcnt <= dcnt + DCNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Repeat FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= ST_IDLE;
            rcnt  <= '0;
            rep   <= 1'b0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
            rep   <= rep_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Repeat FSM: next state. A release always wins over a coinciding
    // terminal count so no repeat is emitted on the release edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        rep_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                rcnt_nxt = '0;
                if (rise) begin
                    rep_nxt   = 1'b1;
                    state_nxt = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (fall) begin
                    rcnt_nxt  = '0;
                    state_nxt = ST_IDLE;
                end else if (rcnt == DELAY_TC) begin
                    rep_nxt   = 1'b1;
                    rcnt_nxt  = '0;
                    state_nxt = ST_REPEAT;
                end else begin
                    rcnt_nxt = rcnt + RCNT_W'(1);
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    rcnt_nxt  = '0;
                    state_nxt = ST_IDLE;
                end else if (rcnt == RATE_TC) begin
                    rep_nxt  = 1'b1;
                    rcnt_nxt = '0;
                end else begin
                    rcnt_nxt = rcnt + RCNT_W'(1);
                end
            end
            default: begin
                rcnt_nxt  = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_util_debounce_repeat.sv
`default_nettype none
// ============================================================================
//  Module   : tb_util_debounce_repeat
//  Purpose  : Directed self-checking bench for util_debounce_repeat with
//             DEBOUNCE=4, REPEAT_DELAY=10, REPEAT_RATE=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_util_debounce_repeat;

    logic clk   = 1'b0;
    logic res_n = 1'b0;
    logic d     = 1'b0;
    logic level;
    logic press;
    logic release_stb;
    logic rep;

    int n_vec = 0;
    int n_err = 0;

    util_debounce_repeat #(
        .DEBOUNCE     (4),
        .REPEAT_DELAY (10),
        .REPEAT_RATE  (3)
    ) dut (
        .clk         (clk),
        .res_n       (res_n),
        .d           (d),
        .level       (level),
        .press       (press),
        .release_stb (release_stb),
        .rep         (rep)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int n,
                              input logic l, input logic p, input logic r, input logic rp);
        check($sformatf("%s e%0d level", tag, n), {31'd0, level},       {31'd0, l});
        check($sformatf("%s e%0d press", tag, n), {31'd0, press},       {31'd0, p});
        check($sformatf("%s e%0d rel",   tag, n), {31'd0, release_stb}, {31'd0, r});
        check($sformatf("%s e%0d rep",   tag, n), {31'd0, rep},         {31'd0, rp});
    endtask

    // Reset with d low; leaves the next rising edge as "edge 1".
    task automatic do_reset();
        d     = 1'b0;
        res_n = 1'b0;
        step();
        step();
        res_n = 1'b1;
    endtask

    // d rises before edge 1; if fall_before != 0 it drops before that edge.
    // Expected: press at 6, repeats at 16,19,22,...; level falls and release
    // pulses at fall_before+5, with no repeat on or after that edge.
    task automatic run_press(input string tag, input int n_edges, input int fall_before);
        int   fe;
        logic el, ep, er, erp;
        fe = (fall_before != 0) ? fall_before + 5 : 1000000;
        d  = 1'b1;
        for (int n = 1; n <= n_edges; n++) begin
            if (fall_before != 0 && n == fall_before) d = 1'b0;
            step();
            el  = (n >= 6) && (n < fe);
            ep  = (n == 6);
            er  = (n == fe);
            erp = ((n == 6) || (n >= 16 && ((n - 16) % 3) == 0)) && (n < fe);
            check_outs(tag, n, el, ep, er, erp);
        end
    endtask

    // d already high while reset releases: fresh press after 6 edges.
    task automatic after_reset_press(input string tag);
        res_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step();
            check_outs(tag, n, n >= 6, n == 6, 1'b0, n == 6);
        end
    endtask

    initial begin
        logic [15:0] pat;

        // 1: reset values with d high, then release of reset
        d     = 1'b1;
        res_n = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            step();
            check_outs("s1 rst", n, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        after_reset_press("s1 post");

        // 2 + 4: clean hold, then release with repeats running until the fall
        do_reset();
        run_press("s2", 30, 0);
        // continuing: edges 31.. are n=31.. ; d drops before edge 31
        begin
            logic el, er, erp;
            d = 1'b0;
            for (int n = 31; n <= 42; n++) begin
                step();
                el  = (n < 36);
                er  = (n == 36);
                erp = (n == 31) || (n == 34);
                check_outs("s4 rel", n, el, 1'b0, er, erp);
            end
        end
        run_press("s4 again", 30, 0);

        // 3: bounce rejection (3 high, 1 low, 3 high, low)
        do_reset();
        pat = 16'b0000_0000_0111_0111;
        for (int n = 1; n <= 16; n++) begin
            d = pat[n-1];
            step();
            check_outs("s3 bounce", n, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // 5: level fall lands on edge 19, a REPEAT terminal count
        do_reset();
        run_press("s5", 24, 14);

        // 6: asynchronous reset between edges while repeating
        do_reset();
        run_press("s6 hold", 19, 0);
        #1;
        res_n = 1'b0;
        #1;
        check_outs("s6 async", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_outs("s6 held", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        after_reset_press("s6 post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
